// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: pattern encodings,
// the colour-bar table and 1280x720p60 timing constants.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_MOVE  = 2'd3
    } pattern_e;

    localparam logic [23:0] RGB_WHITE = 24'hFF_FFFF;
    localparam logic [23:0] RGB_BLACK = 24'h00_0000;

    // Classic bar order, full-scale levels only: index 0 is the leftmost bar.
    localparam logic [23:0] BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    localparam int H_TOTAL_720P     = 1650;
    localparam int H_ACT_START_720P = 260;
    localparam int H_ACTIVE_720P    = 1280;
    localparam int V_TOTAL_720P     = 750;
    localparam int V_ACT_START_720P = 25;
    localparam int V_ACTIVE_720P    = 720;

    localparam int MOVING_BAR_W     = 16;

endpackage

// File: rtl/pattern_color_lut.sv
// Combinational colour-bar lookup shared by the static and moving-bar patterns.
module pattern_color_lut
    import video_pkg::*;
(
    input  logic [2:0]  bar_idx,
    output logic [23:0] color
);

    assign color = BAR_COLORS[bar_idx];

endmodule

// File: rtl/video_pattern_gen.sv
// Two-stage test-pattern renderer: decodes the active window from the pixel
// counters and emits RGB, data-enable and delayed syncs, all cycle-aligned.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACT_START = H_ACT_START_720P,
    parameter int H_ACTIVE    = H_ACTIVE_720P,
    parameter int V_ACT_START = V_ACT_START_720P,
    parameter int V_ACTIVE    = V_ACTIVE_720P,
    parameter int BAR_STEP    = 4
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [11:0] h_count,
    input  logic [11:0] v_count,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_start,
    input  logic [1:0]  mode_sel,
    output logic [23:0] rgb,
    output logic        de,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [11:0]      H_START  = 12'(H_ACT_START);
    localparam logic [11:0]      H_STOP   = 12'(H_ACT_START + H_ACTIVE);
    localparam logic [11:0]      V_START  = 12'(V_ACT_START);
    localparam logic [11:0]      V_STOP   = 12'(V_ACT_START + V_ACTIVE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BAR_W - 1);

    logic             in_active;
    logic [10:0]      x_next;

    logic             s1_active;
    logic [10:0]      s1_x;
    logic             s1_y_tile;
    logic             s1_hsync;
    logic             s1_vsync;
    logic [2:0]       bar_idx;
    logic [COL_W-1:0] bar_col;

    pattern_e         mode_q;
    logic [10:0]      bar_pos;
    logic [11:0]      bar_sum;
    logic [11:0]      bar_end;
    logic             on_bar;
    logic [23:0]      lut_color;
    logic [23:0]      pixel;

    assign in_active = (h_count >= H_START) && (h_count < H_STOP) &&
                       (v_count >= V_START) && (v_count < V_STOP);
    assign x_next    = h_count[10:0] - H_START[10:0];
    assign bar_sum   = {1'b0, bar_pos} + 12'(BAR_STEP);

    // Stage 1: window decode, local coordinates, bar counters and sync delay.
    // The bar counters hold the index of the pixel currently in this stage.
    // NOTE: every register here uses <=, so all stage-1 values update together on the edge.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_active <= 1'b0;
            s1_x      <= '0;
            s1_y_tile <= 1'b0;
            s1_hsync  <= 1'b0;
            s1_vsync  <= 1'b0;
            bar_idx   <= '0;
            bar_col   <= '0;
        end else begin
            s1_active <= in_active;
            s1_x      <= x_next;
            s1_y_tile <= 1'((v_count[5:0] - V_START[5:0]) >> 5);
            s1_hsync  <= hsync_in;
            s1_vsync  <= vsync_in;
            if (in_active) begin
                if (x_next == '0) begin
                    bar_col <= '0;
                    bar_idx <= '0;
                end else if (bar_col == COL_LAST) begin
                    bar_col <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_col <= bar_col + COL_W'(1);
                end
            end
        end
    end

    // Mode and bar position change only on frame_start, so a frame never tears.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= PAT_BARS;
            bar_pos <= '0;
        end else if (frame_start) begin
            mode_q  <= pattern_e'(mode_sel);
            bar_pos <= (bar_sum >= 12'(H_ACTIVE)) ? '0 : bar_sum[10:0];
        end
    end

    pattern_color_lut u_lut (
        .bar_idx (bar_idx),
        .color   (lut_color)
    );

    assign bar_end = {1'b0, bar_pos} + 12'(MOVING_BAR_W);
    assign on_bar  = (s1_x >= bar_pos) && ({1'b0, s1_x} < bar_end);

    // NOTE: pixel gets a default before the case so no latch is inferred.
    always_comb begin
        pixel = RGB_BLACK;
        case (mode_q)
            PAT_BARS:  pixel = lut_color;
            PAT_GRAD:  pixel = {3{s1_x[7:0]}};
            PAT_CHECK: pixel = (s1_x[5] ^ s1_y_tile) ? RGB_WHITE : RGB_BLACK;
            PAT_MOVE:  pixel = on_bar ? RGB_WHITE : lut_color;
            default:   pixel = RGB_BLACK;
        endcase
        if (!s1_active) begin
            pixel = RGB_BLACK;
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= '0;
            de        <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb       <= pixel;
            de        <= s1_active;
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: the bench acts as the counter
// stage and compares every line against a pixel-level reference model.
module tb_video_pattern_gen;

    localparam int H_TOTAL = 1650;
    localparam int H_START = 260;
    localparam int H_ACT   = 1280;
    localparam int V_START = 25;
    localparam int V_ACT   = 720;
    localparam int STEP    = 4;
    localparam int BAR_W   = H_ACT / 8;

    logic        pixel_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic [11:0] h_count   = '0;
    logic [11:0] v_count   = '0;
    logic        hsync_in  = 1'b0;
    logic        vsync_in  = 1'b0;
    logic        frame_start = 1'b0;
    logic [1:0]  mode_sel  = '0;
    logic [23:0] rgb;
    logic        de;
    logic        hsync_out;
    logic        vsync_out;

    int errors = 0;
    int checks = 0;

    always #5 pixel_clk = ~pixel_clk;

    video_pattern_gen dut (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n),
        .h_count     (h_count),
        .v_count     (v_count),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .frame_start (frame_start),
        .mode_sel    (mode_sel),
        .rgb         (rgb),
        .de          (de),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        rgb_valid;
    } px_t;

    logic [23:0] bar_table [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    int  m_mode   = 0;
    int  m_bar    = 0;
    bit  m_synced = 1'b0;
    px_t prev_e   = '0;
    int  prev_tag = -1;
    px_t exp_line [H_TOTAL];
    px_t got_line [H_TOTAL];
    int  d;

    function automatic px_t zero_px();
        px_t p;
        p = '0;
        p.rgb_valid = 1'b1;
        return p;
    endfunction

    function automatic px_t model_pixel(int h, int v, bit hs, bit vs);
        px_t p;
        int  x, y, idx;
        p = zero_px();
        p.hs = hs;
        p.vs = vs;
        if (h >= H_START && h < H_START + H_ACT && v >= V_START && v < V_START + V_ACT) begin
            x = h - H_START;
            y = v - V_START;
            idx = x / BAR_W;
            p.de = 1'b1;
            p.rgb_valid = m_synced;
            case (m_mode)
                0: p.rgb = bar_table[idx];
                1: p.rgb = 24'((x % 256) * 24'h010101);
                2: p.rgb = (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
                default: p.rgb = (x >= m_bar && x < m_bar + 16) ? 24'hFFFFFF : bar_table[idx];
            endcase
        end
        return p;
    endfunction

    // Drive one pixel; records the DUT output of the previous pixel (2-cycle latency
    // means the output sampled just after this edge belongs to the previous call).
    task automatic drive(int h, int v, bit hs, bit vs, bit fs, int tag);
        px_t e_new, cur;
        bit  in_rst;
        in_rst = !rst_n;
        h_count = 12'(h);
        v_count = 12'(v);
        hsync_in = hs;
        vsync_in = vs;
        frame_start = fs;
        e_new = zero_px();
        if (!in_rst) begin
            if (fs) begin
                m_mode = int'(mode_sel);
                m_bar  = (m_bar + STEP >= H_ACT) ? 0 : m_bar + STEP;
            end
            if (h == H_START && v >= V_START && v < V_START + V_ACT) m_synced = 1'b1;
            e_new = model_pixel(h, v, hs, vs);
        end
        @(posedge pixel_clk);
        #1;
        if (in_rst) begin
            cur = zero_px();
            prev_e = zero_px();
            m_mode = 0;
            m_bar = 0;
            m_synced = 1'b0;
        end else begin
            cur = prev_e;
            prev_e = e_new;
        end
        if (prev_tag >= 0) begin
            exp_line[prev_tag] = cur;
            got_line[prev_tag] = {rgb, de, hsync_out, vsync_out, 1'b1};
        end
        prev_tag = tag;
    endtask

    task automatic frame_pulse();
        drive(0, 0, 1'b1, 1'b1, 1'b1, -1);
    endtask

    task automatic run_line(int v, bit hs_pol, bit vs);
        for (int h = 0; h < H_TOTAL; h++) drive(h, v, (h < 40) ^ hs_pol, vs, 1'b0, h);
        drive(H_TOTAL - 1, v, hs_pol, vs, 1'b0, -1);
    endtask

    function automatic int first_diff();
        for (int h = 0; h < H_TOTAL; h++) begin
            if (got_line[h].de !== exp_line[h].de || got_line[h].hs !== exp_line[h].hs ||
                got_line[h].vs !== exp_line[h].vs) return h;
            if (exp_line[h].rgb_valid && got_line[h].rgb !== exp_line[h].rgb) return h;
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        mode_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            drive(H_START + i, V_START, 1'b1, 1'b1, 1'b1, -1);
            checks++;
            if ({rgb, de, hsync_out, vsync_out} !== 27'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got rgb=%h de=%b hs=%b vs=%b want all 0",
                         i, rgb, de, hsync_out, vsync_out);
            end
        end
        rst_n = 1'b1;
        mode_sel = 2'd0;
    endtask

    task automatic test_bars();
        int          hpts [6] = '{260, 419, 420, 579, 1380, 1539};
        logic [23:0] vals [6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h000000, 24'h000000};
        int          lines [4] = '{24, 25, 744, 745};
        mode_sel = 2'd0;
        frame_pulse();
        run_line(25, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_line[hpts[i]].rgb !== vals[i]) begin
                errors++;
                $display("FAIL bars_rgb h=%0d got=%h want=%h", hpts[i], got_line[hpts[i]].rgb, vals[i]);
            end
        end
        checks++;
        if ({got_line[259].de, got_line[260].de, got_line[1539].de, got_line[1540].de} !== 4'b0110) begin
            errors++;
            $display("FAIL bars_de_edges got=%b%b%b%b want=0110", got_line[259].de,
                     got_line[260].de, got_line[1539].de, got_line[1540].de);
        end
        foreach (lines[i]) begin
            run_line(lines[i], 1'($urandom), 1'($urandom));
            d = first_diff();
            checks++;
            if (d >= 0) begin
                errors++;
                $display("FAIL bars_line v=%0d h=%0d got=%h want=%h", lines[i], d, got_line[d], exp_line[d]);
            end
        end
    endtask

    task automatic test_gradient();
        int          xs   [4] = '{0, 255, 256, 300};
        logic [23:0] vals [4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'h2C2C2C};
        mode_sel = 2'd1;
        frame_pulse();
        run_line(30, 1'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_line[H_START + xs[i]].rgb !== vals[i]) begin
                errors++;
                $display("FAIL grad_rgb x=%0d got=%h want=%h", xs[i], got_line[H_START + xs[i]].rgb, vals[i]);
            end
        end
        d = first_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL grad_line h=%0d got=%h want=%h", d, got_line[d], exp_line[d]);
        end
    endtask

    task automatic test_checker();
        mode_sel = 2'd2;
        frame_pulse();
        run_line(V_START, 1'b0, 1'b0);
        checks++;
        if (got_line[H_START].rgb !== 24'h000000 || got_line[H_START + 32].rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL check_row0 got x0=%h x32=%h want 000000 FFFFFF",
                     got_line[H_START].rgb, got_line[H_START + 32].rgb);
        end
        run_line(V_START + 32, 1'b1, 1'b0);
        checks++;
        if (got_line[H_START + 32].rgb !== 24'h000000 || got_line[H_START].rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL check_row32 got x32=%h x0=%h want 000000 FFFFFF",
                     got_line[H_START + 32].rgb, got_line[H_START].rgb);
        end
        d = first_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL check_line h=%0d got=%h want=%h", d, got_line[d], exp_line[d]);
        end
    endtask

    task automatic test_moving_bar();
        int guard;
        mode_sel = 2'd3;
        for (int f = 0; f < 3; f++) begin
            frame_pulse();
            run_line($urandom_range(V_START, V_START + V_ACT - 1), 1'($urandom), 1'b0);
            d = first_diff();
            checks++;
            if (d >= 0 || got_line[H_START + m_bar + 15].rgb !== 24'hFFFFFF) begin
                errors++;
                $display("FAIL move_frame f=%0d bar=%0d diff_h=%0d", f, m_bar, d);
            end
        end
        guard = 0;
        while (m_bar != H_ACT - 2 * STEP && guard < 400) begin
            frame_pulse();
            guard++;
        end
        frame_pulse();
        run_line(V_START + 100, 1'b0, 1'b0);
        checks++;
        if (got_line[H_START + 1275].rgb !== 24'h000000 || got_line[H_START + 1276].rgb !== 24'hFFFFFF ||
            got_line[H_START + 1279].rgb !== 24'hFFFFFF || got_line[H_START + 1259].rgb !== 24'h000000) begin
            errors++;
            $display("FAIL move_clip got x1259=%h x1275=%h x1276=%h x1279=%h want 000000 000000 FFFFFF FFFFFF",
                     got_line[H_START + 1259].rgb, got_line[H_START + 1275].rgb,
                     got_line[H_START + 1276].rgb, got_line[H_START + 1279].rgb);
        end
        frame_pulse();
        run_line(V_START + 101, 1'b0, 1'b0);
        d = first_diff();
        checks++;
        if (d >= 0 || got_line[H_START + 1276].rgb !== 24'h000000) begin
            errors++;
            $display("FAIL move_wrap diff_h=%0d x1276=%h want 000000", d, got_line[H_START + 1276].rgb);
        end
    endtask

    task automatic test_mode_change();
        mode_sel = 2'd0;
        frame_pulse();
        run_line(399, 1'b0, 1'b0);
        mode_sel = 2'd2;
        run_line(400, 1'b0, 1'b0);
        checks++;
        if (got_line[H_START + 40].rgb !== 24'hFFFFFF || first_diff() >= 0) begin
            errors++;
            $display("FAIL mode_hold x40=%h want FFFFFF", got_line[H_START + 40].rgb);
        end
        frame_pulse();
        run_line(400, 1'b0, 1'b0);
        checks++;
        if (got_line[H_START + 40].rgb !== 24'h000000 || first_diff() >= 0) begin
            errors++;
            $display("FAIL mode_switch x40=%h want 000000", got_line[H_START + 40].rgb);
        end
    endtask

    task automatic test_reset_midline();
        mode_sel = 2'd2;
        frame_pulse();
        for (int h = 0; h <= 700; h++) drive(h, 100, h >= 40, 1'b1, 1'b0, h);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rgb, de, hsync_out, vsync_out} !== 27'd0) begin
            errors++;
            $display("FAIL midreset_async got rgb=%h de=%b hs=%b vs=%b want all 0",
                     rgb, de, hsync_out, vsync_out);
        end
        for (int h = 701; h <= 703; h++) drive(h, 100, 1'b1, 1'b1, 1'b0, h);
        rst_n = 1'b1;
        for (int h = 704; h < H_TOTAL; h++) drive(h, 100, 1'($urandom), 1'($urandom), 1'b0, h);
        drive(H_TOTAL - 1, 100, 1'b0, 1'b0, 1'b0, -1);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL midreset_line h=%0d got=%h want=%h", d, got_line[d], exp_line[d]);
        end
        run_line(101, 1'b0, 1'b0);
        checks++;
        if (got_line[H_START + 160].rgb !== 24'hFFFF00 || first_diff() >= 0) begin
            errors++;
            $display("FAIL midreset_mode0 x160=%h want FFFF00", got_line[H_START + 160].rgb);
        end
        mode_sel = 2'd3;
        frame_pulse();
        run_line(102, 1'b0, 1'b0);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL midreset_bar h=%0d got=%h want=%h", d, got_line[d], exp_line[d]);
        end
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 4; i++) begin
            mode_sel = 2'($urandom);
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) frame_pulse();
            mode_sel = 2'($urandom);
            v = $urandom_range(V_START - 2, V_START + V_ACT + 1);
            run_line(v, 1'($urandom), 1'($urandom));
            d = first_diff();
            checks++;
            if (d >= 0) begin
                errors++;
                $display("FAIL random_line i=%0d v=%0d mode=%0d h=%0d got=%h want=%h",
                         i, v, m_mode, d, got_line[d], exp_line[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_gradient();
        test_checker();
        test_moving_bar();
        test_mode_change();
        test_reset_midline();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
